// File: rtl/gate_sensor_fsm.sv
// Vehicle access gate front end: synchronises and debounces two beam sensors,
// tracks passage direction and issues registered enter/exit/denied/fault pulses.
//   clk, reset              : clock, asynchronous active-high reset
//   sens_out, sens_in       : raw outer / inner beams (1 = broken), async to clk
//   lot_full                : 1 = no free space, checked only when an entry starts
//   cor_enter, cor_exit     : one-cycle pulses per completed passage
//   gate_open               : barrier raise, high while a passage is in progress
//   denied, fault           : one-cycle pulses on refused entry / passage timeout
module gate_sensor_fsm #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sens_out,
  input  logic sens_in,
  input  logic lot_full,
  output logic cor_enter,
  output logic cor_exit,
  output logic gate_open,
  output logic denied,
  output logic fault
);

  localparam int unsigned DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, E1, E2, E3, X1, X2, X3, WAIT_CLR
  } state_t;

  logic [1:0] raw;
  logic [1:0] deb;
  logic       a;
  logic       b;

  assign raw = {sens_out, sens_in};
  assign a   = deb[1];
  assign b   = deb[0];

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic          s1;
    logic          s2;
    logic          d;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        d   <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        if (s2 == d) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          d   <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign deb[g] = d;
  end

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          enter_nxt, exit_nxt, denied_nxt, fault_nxt;

  always_comb begin
    state_nxt  = state;
    tcnt_nxt   = '0;
    enter_nxt  = 1'b0;
    exit_nxt   = 1'b0;
    denied_nxt = 1'b0;
    fault_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (a && !b) begin
          if (lot_full) begin
            state_nxt  = WAIT_CLR;
            denied_nxt = 1'b1;
          end else begin
            state_nxt = E1;
          end
        end else if (!a && b) begin
          state_nxt = X1;
        end else if (a && b) begin
          state_nxt = WAIT_CLR;
        end
      end
      E1: case ({a, b})
        2'b11:   state_nxt = E2;
        2'b00:   state_nxt = IDLE;
        2'b01:   state_nxt = WAIT_CLR;
        default: ;
      endcase
      E2: case ({a, b})
        2'b01:   state_nxt = E3;
        2'b10:   state_nxt = E1;
        2'b00:   state_nxt = IDLE;
        default: ;
      endcase
      E3: case ({a, b})
        2'b00: begin
          state_nxt = IDLE;
          enter_nxt = 1'b1;
        end
        2'b11:   state_nxt = E2;
        2'b10:   state_nxt = WAIT_CLR;
        default: ;
      endcase
      X1: case ({a, b})
        2'b11:   state_nxt = X2;
        2'b00:   state_nxt = IDLE;
        2'b10:   state_nxt = WAIT_CLR;
        default: ;
      endcase
      X2: case ({a, b})
        2'b10:   state_nxt = X3;
        2'b01:   state_nxt = X1;
        2'b00:   state_nxt = IDLE;
        default: ;
      endcase
      X3: case ({a, b})
        2'b00: begin
          state_nxt = IDLE;
          exit_nxt  = 1'b1;
        end
        2'b11:   state_nxt = X2;
        2'b01:   state_nxt = WAIT_CLR;
        default: ;
      endcase
      WAIT_CLR: if (!a && !b) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    // Timeout only where no transition was taken, so it never collides with a completion pulse.
    if ((state inside {E1, E2, E3, X1, X2, X3}) && (state_nxt == state)) begin
      if (tcnt == TO_LAST) begin
        state_nxt = WAIT_CLR;
        fault_nxt = 1'b1;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      cor_enter <= 1'b0;
      cor_exit  <= 1'b0;
      gate_open <= 1'b0;
      denied    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      cor_enter <= enter_nxt;
      cor_exit  <= exit_nxt;
      gate_open <= state_nxt inside {E1, E2, E3, X1, X2, X3};
      denied    <= denied_nxt;
      fault     <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_gate_sensor_fsm.sv
module tb_gate_sensor_fsm;

  localparam int DEB = 4;
  localparam int TO  = 64;

  logic clk, reset, sens_out, sens_in, lot_full;
  logic cor_enter, cor_exit, gate_open, denied, fault;

  gate_sensor_fsm #(.DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .sens_out(sens_out), .sens_in(sens_in),
    .lot_full(lot_full), .cor_enter(cor_enter), .cor_exit(cor_exit),
    .gate_open(gate_open), .denied(denied), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: passage tracked as (direction, step 1..3) with the
  // lead/trail beam rule; phase 0 = idle, 4 = waiting for clear.
  bit m_s1a, m_s2a, m_s1b, m_s2b, m_a, m_b;
  bit qa[$], qb[$];
  int m_ph, m_dwell;
  bit m_dir;
  bit m_en, m_ex, m_den, m_flt, m_gate;

  function automatic bit settle(input bit q[$], input bit cur);
    if (q.size() < DEB) return cur;
    foreach (q[i]) if (q[i] == cur) return cur;
    return !cur;
  endfunction

  function automatic int step_next(input int st, input bit lead, input bit trail);
    case (st)
      1: if (lead && trail) return 2; else if (!lead && !trail) return 0;
         else if (!lead && trail) return 4; else return 1;
      2: if (!lead && trail) return 3; else if (lead && !trail) return 1;
         else if (!lead && !trail) return 0; else return 2;
      default: if (!lead && !trail) return 0; else if (lead && trail) return 2;
         else if (lead && !trail) return 4; else return 3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0; m_a = 0; m_b = 0;
      qa.delete(); qb.delete();
      m_ph = 0; m_dwell = 0; m_dir = 0;
      m_en = 0; m_ex = 0; m_den = 0; m_flt = 0; m_gate = 0;
    end else begin
      int nph;
      bit lead, trail;
      m_en = 0; m_ex = 0; m_den = 0; m_flt = 0;
      nph = m_ph;
      if (m_ph == 0) begin
        if (m_a && !m_b) begin
          if (lot_full) begin nph = 4; m_den = 1; end
          else begin nph = 1; m_dir = 1; end
        end else if (!m_a && m_b) begin
          nph = 1; m_dir = 0;
        end else if (m_a && m_b) begin
          nph = 4;
        end
      end else if (m_ph == 4) begin
        if (!m_a && !m_b) nph = 0;
      end else begin
        lead  = m_dir ? m_a : m_b;
        trail = m_dir ? m_b : m_a;
        nph = step_next(m_ph, lead, trail);
        if (m_ph == 3 && nph == 0) begin
          if (m_dir) m_en = 1; else m_ex = 1;
        end
        if (nph == m_ph) begin
          m_dwell++;
          if (m_dwell == TO - 1) begin nph = 4; m_flt = 1; end
        end
      end
      if (nph != m_ph || nph == 0 || nph == 4) m_dwell = 0;
      m_ph = nph;
      m_gate = (nph >= 1 && nph <= 3);
      qa.push_back(m_s2a); if (qa.size() > DEB) void'(qa.pop_front());
      qb.push_back(m_s2b); if (qb.size() > DEB) void'(qb.pop_front());
      if (settle(qa, m_a) != m_a) begin m_a = !m_a; qa.delete(); end
      if (settle(qb, m_b) != m_b) begin m_b = !m_b; qb.delete(); end
      m_s2a = m_s1a; m_s1a = sens_out;
      m_s2b = m_s1b; m_s1b = sens_in;
    end
  end

  always @(negedge clk) begin
    check("mdl_cor_enter", cor_enter, m_en);
    check("mdl_cor_exit",  cor_exit,  m_ex);
    check("mdl_denied",    denied,    m_den);
    check("mdl_fault",     fault,     m_flt);
    check("mdl_gate_open", gate_open, m_gate);
  end

  int n_en, n_ex, n_den, n_flt, n_gate, t_en, t_ex, t_den, t_flt, t_gate;

  task automatic clr_stats();
    n_en = 0; n_ex = 0; n_den = 0; n_flt = 0; n_gate = 0;
    t_en = -1; t_ex = -1; t_den = -1; t_flt = -1; t_gate = -1;
  endtask

  task automatic step();
    @(negedge clk);
    if (cor_enter) begin n_en++;  t_en  = cyc; end
    if (cor_exit)  begin n_ex++;  t_ex  = cyc; end
    if (denied)    begin n_den++; t_den = cyc; end
    if (fault)     begin n_flt++; t_flt = cyc; end
    if (gate_open) begin
      if (n_gate == 0) t_gate = cyc;
      n_gate++;
    end
  endtask

  task automatic hold(input logic so, input logic si, input int n);
    sens_out = so;
    sens_in  = si;
    repeat (n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, trel;
    reset = 1'b1; sens_out = 1'b0; sens_in = 1'b0; lot_full = 1'b0;
    clr_stats();
    repeat (3) step();
    check("reset_outputs", {cor_enter, cor_exit, gate_open, denied, fault}, 0);
    reset = 1'b0;
    repeat (3) step();

    // Entry
    clr_stats();
    t0 = cyc;
    hold(1, 0, 20); hold(1, 1, 20);
    hold(0, 1, 20);
    trel = cyc;
    hold(0, 0, 20);
    check("entry_enter_count", n_en, 1);
    check("entry_enter_delay", t_en - trel, 7);
    check("entry_gate_rise",   t_gate - t0, 7);
    check("entry_gate_cycles", n_gate, 60);
    check("entry_other",       n_ex + n_den + n_flt, 0);

    // Exit
    clr_stats();
    hold(0, 1, 20); hold(1, 1, 20);
    hold(1, 0, 20);
    trel = cyc;
    hold(0, 0, 20);
    check("exit_exit_count", n_ex, 1);
    check("exit_exit_delay", t_ex - trel, 7);
    check("exit_other",      n_en + n_den + n_flt, 0);

    // Full lot
    clr_stats();
    lot_full = 1'b1;
    t0 = cyc;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
    lot_full = 1'b0;
    check("full_denied_count", n_den, 1);
    check("full_denied_delay", t_den - t0, 7);
    check("full_gate_cycles",  n_gate, 0);
    check("full_enter_count",  n_en, 0);

    // Backout
    clr_stats();
    hold(1, 0, 20); hold(0, 0, 20);
    check("backout_pulses",      n_en + n_ex + n_den + n_flt, 0);
    check("backout_gate_cycles", n_gate, 20);

    // Glitch shorter than the debounce window
    clr_stats();
    hold(0, 1, 3); hold(0, 0, 20);
    check("glitch_pulses",      n_en + n_ex + n_den + n_flt, 0);
    check("glitch_gate_cycles", n_gate, 0);

    // Timeout
    clr_stats();
    t0 = cyc;
    hold(1, 0, 100);
    check("timeout_fault_count", n_flt, 1);
    check("timeout_fault_delay", t_flt - t0, 70);
    check("timeout_gate_cycles", n_gate, 63);
    check("timeout_gate_low",    gate_open, 0);
    hold(0, 0, 20);
    check("timeout_other", n_en + n_ex + n_den, 0);

    // Async reset mid-E2, then a clean entry
    clr_stats();
    hold(1, 0, 20); hold(1, 1, 15);
    check("pre_reset_gate", gate_open, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    sens_out = 1'b0; sens_in = 1'b0;
    #1 check("async_reset_outputs", {cor_enter, cor_exit, gate_open, denied, fault}, 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    clr_stats();
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
    check("post_reset_enter", n_en, 1);
    check("post_reset_other", n_ex + n_den + n_flt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
